gray_decoder: RTL and testbench
===============================

GRAY_DECODER -- requirements
Module: gray_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning the Gray/binary code width in bits (legal range 2..8).
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Valid  input  1  Gray input is sampled on this cycle.
REQ-005 SHALL have port Gray  input  WIDTH  Gray-coded count from the upstream encoder.
REQ-006 SHALL have port Clear  input  1  synchronous; drops lock and clears the sticky flags.
REQ-007 SHALL have port Binary  output  WIDTH  registered decoded count.
REQ-008 SHALL have port Locked  output  1  high while state is LOCKED.
REQ-009 SHALL have port Wrap  output  1  sticky; set on a max-to-0 step.
REQ-010 SHALL have port Error  output  1  sticky; set on an illegal step.

Function
REQ-011 SHALL decode combinationally as follows: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i from WIDTH-2 down to 0.
REQ-012 SHALL implement a three-state FSM with states EMPTY, LOCKED and FAULT.
REQ-013 SHALL, in EMPTY with Valid=1, load the decoded value d into Binary and go to LOCKED, with no step check.
REQ-014 SHALL, in LOCKED with Valid=1 and d==Binary, hold all outputs (a repeated code is legal).
REQ-015 SHALL, in LOCKED with Valid=1 and d==Binary+1 mod 2^WIDTH, load d into Binary.
REQ-016 SHALL also set Wrap in the case of REQ-015 when the old Binary equals 2^WIDTH-1.
REQ-017 SHALL, in LOCKED with Valid=1 and any other d, set Error, hold Binary and go to FAULT.
REQ-018 SHALL, in FAULT, ignore Valid and hold Binary and the flags until Clear or Reset.
REQ-019 SHALL, on Clear=1 in any state, go to EMPTY, clear Wrap and Error, and hold Binary.
REQ-020 SHALL give Clear priority over Valid in the same cycle; that sample is discarded.
REQ-021 SHALL ignore the Gray input whenever Valid=0.
REQ-022 SHALL update all outputs exactly one Clk edge after the sampling edge (latency 1).
REQ-023 SHALL treat a backward step (d==Binary-1) as illegal.

Reset
REQ-024 SHALL, while Reset=1, immediately and without a Clk edge force state EMPTY, Binary=0, Locked=0, Wrap=0 and Error=0.
REQ-025 SHALL give Reset priority over Clear and Valid.
REQ-026 SHALL treat a Reset asserted mid-stream like power-up; the first Valid after release relocks without a step check.

Configuration
REQ-027 SHALL, when macro GRAY_DECODER_ERRCNT_EN is defined, add output ErrCount (output, 8 bits).
REQ-028 SHALL, with GRAY_DECODER_ERRCNT_EN defined, increment ErrCount by 1 on each LOCKED-to-FAULT transition.
REQ-029 SHALL, with GRAY_DECODER_ERRCNT_EN defined, saturate ErrCount at 255.
REQ-030 SHALL, with GRAY_DECODER_ERRCNT_EN defined, clear ErrCount on Reset only, not on Clear.
REQ-031 SHALL, without GRAY_DECODER_ERRCNT_EN, have no ErrCount port and no counter logic.

Structure
REQ-032 SHALL take the FSM state typedef (EMPTY/LOCKED/FAULT) and the ErrCount width constant (8) from shared package gray_pkg.
REQ-033 SHALL place the Gray-to-binary conversion in a combinational sub-module gray2bin, parameterised by WIDTH.

Verification (WIDTH=3)
REQ-034 SHALL cover: Reset, then Valid with Gray 000,001,011,010,110,111,101,100,000 -> Binary 0..7 then 0; Wrap=1 after the final sample; Error=0; Locked=1.
REQ-035 SHALL cover: LOCKED at Binary=2, Gray 011 applied twice -> Binary stays 2; Error=0.
REQ-036 SHALL cover: Binary=1, Gray 010 (d=3) -> next edge Error=1, Locked=0, Binary=1; following Gray 011 ignored.
REQ-037 SHALL cover: in FAULT, Clear=1 together with Valid/Gray 110 -> Error=0, Wrap=0, state EMPTY, sample discarded; next Valid Gray 110 -> Binary=4, Locked=1.
REQ-038 SHALL cover: Reset pulsed between Clk edges at Binary=5 -> Binary=0, Locked=0 immediately; first Valid Gray 101 after release -> Binary=6 with no Error.
REQ-039 SHALL cover, with GRAY_DECODER_ERRCNT_EN: 3 faults each followed by Clear -> ErrCount=3; 260 faults -> ErrCount=255.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code decoder.
package gray_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StLocked,
        StFault
    } state_e;

    localparam int unsigned ErrCntWidth = 8;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary conversion, parameterised by code width.
module gray2bin #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    // b[i] = b[i+1] ^ g[i] unrolled: each bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign binary[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_decoder.sv
// Registered Gray-code decoder with lock/fault tracking and sticky Wrap/Error flags.
// Optional fault counter output ErrCount is enabled by defining GRAY_DECODER_ERRCNT_EN.
module gray_decoder
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Gray,
    input  logic             Clear,
    output logic [WIDTH-1:0] Binary,
    output logic             Locked,
    output logic             Wrap,
    output logic             Error
`ifdef GRAY_DECODER_ERRCNT_EN
    ,
    output logic [ErrCntWidth-1:0] ErrCount
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d, bin_inc, dec;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    gray2bin #(
        .WIDTH(WIDTH)
    ) u_gray2bin (
        .gray  (Gray),
        .binary(dec)
    );

    assign bin_inc = bin_q + 1'b1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        // Clear wins over Valid; the coincident sample is dropped.
        if (Clear) begin
            state_d = StEmpty;
            wrap_d  = 1'b0;
            err_d   = 1'b0;
        end else if (Valid) begin
            case (state_q)
                StEmpty: begin
                    bin_d   = dec;
                    state_d = StLocked;
                end
                StLocked: begin
                    if (dec == bin_inc) begin
                        bin_d = dec;
                        if (&bin_q) begin
                            wrap_d = 1'b1;
                        end
                    end else if (dec != bin_q) begin
                        err_d   = 1'b1;
                        state_d = StFault;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StEmpty;
            bin_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign Binary = bin_q;
    assign Locked = (state_q == StLocked);
    assign Wrap   = wrap_q;
    assign Error  = err_q;

`ifdef GRAY_DECODER_ERRCNT_EN
    logic                   fault_ev;
    logic [ErrCntWidth-1:0] cnt_q;

    assign fault_ev = (state_q == StLocked) && (state_d == StFault);

    // Saturating; only Reset clears it so faults accumulate across Clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (fault_ev && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ErrCount = cnt_q;
`else
    // Fault events are not counted in this build.
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder (WIDTH=3): vector table, corner sequences, random vs model.
module tb_gray_decoder;

    localparam int W = 3;

    logic         Clk;
    logic         Reset;
    logic         Valid;
    logic         Clear;
    logic [W-1:0] Gray;
    logic [W-1:0] Binary;
    logic         Locked;
    logic         Wrap;
    logic         Error;
`ifdef GRAY_DECODER_ERRCNT_EN
    logic [7:0]   ErrCount;
`endif

    gray_decoder #(
        .WIDTH(W)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Valid (Valid),
        .Gray  (Gray),
        .Clear (Clear),
        .Binary(Binary),
        .Locked(Locked),
        .Wrap  (Wrap),
`ifdef GRAY_DECODER_ERRCNT_EN
        .Error (Error),
        .ErrCount(ErrCount)
`else
        .Error (Error)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=empty, 1=locked, 2=fault.
    int m_mode, m_bin, m_wrap, m_err, m_cnt;

    typedef struct {
        logic         valid;
        logic         clear;
        logic [W-1:0] gray;
        logic [W-1:0] bin;
        logic         locked;
        logic         wrap;
        logic         err;
    } vec_t;

    vec_t vecs[19];

    function automatic int gray_of(int n);
        return n ^ (n >> 1);
    endfunction

    // Decode by searching the code table rather than via the XOR chain.
    function automatic int model_dec(int g);
        for (int n = 0; n < (1 << W); n++) begin
            if (gray_of(n) == g) return n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_bin = 0; m_wrap = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic v, input logic c, input logic [W-1:0] g);
        int d;
        d = model_dec(int'(g));
        if (c) begin
            m_mode = 0; m_wrap = 0; m_err = 0;
        end else if (v) begin
            if (m_mode == 0) begin
                m_bin = d; m_mode = 1;
            end else if (m_mode == 1) begin
                if (d == (m_bin + 1) % (1 << W)) begin
                    if (m_bin == (1 << W) - 1) m_wrap = 1;
                    m_bin = d;
                end else if (d != m_bin) begin
                    m_err = 1; m_mode = 2;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dut_out();
        return 16'({Binary, Locked, Wrap, Error});
    endfunction

    function automatic logic [15:0] model_out();
        logic [W-1:0] mb;
        mb = W'(m_bin);
        return 16'({mb, m_mode == 1, m_wrap != 0, m_err != 0});
    endfunction

    task automatic check_model(input string name);
        check(name, dut_out(), model_out());
`ifdef GRAY_DECODER_ERRCNT_EN
        check({name, "_cnt"}, 16'(ErrCount), 16'(m_cnt));
`endif
    endtask

    task automatic drive(input logic v, input logic c, input logic [W-1:0] g);
        Valid = v; Clear = c; Gray = g;
        @(posedge Clk);
        #1;
        Valid = 1'b0; Clear = 1'b0;
        model_step(v, c, g);
    endtask

    // Reset asserted and released between edges; outputs must clear without a clock.
    task automatic pulse_reset(input string name);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check(name, dut_out(), model_out());
        #1 Reset = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic v, input logic c, input logic [W-1:0] g,
                           input logic [W-1:0] b, input logic l, input logic wr, input logic e);
        vecs[i].valid = v; vecs[i].clear = c; vecs[i].gray = g;
        vecs[i].bin = b; vecs[i].locked = l; vecs[i].wrap = wr; vecs[i].err = e;
    endtask

    initial begin
        int          r;
        logic        v, c;
        logic [W-1:0] g;

        // Full count with wrap, repeat, ignored sample, clear, fault, clear-with-valid.
        set_vec( 0, 1, 0, 3'b000, 3'd0, 1, 0, 0);
        set_vec( 1, 1, 0, 3'b001, 3'd1, 1, 0, 0);
        set_vec( 2, 1, 0, 3'b011, 3'd2, 1, 0, 0);
        set_vec( 3, 1, 0, 3'b010, 3'd3, 1, 0, 0);
        set_vec( 4, 1, 0, 3'b110, 3'd4, 1, 0, 0);
        set_vec( 5, 1, 0, 3'b111, 3'd5, 1, 0, 0);
        set_vec( 6, 1, 0, 3'b101, 3'd6, 1, 0, 0);
        set_vec( 7, 1, 0, 3'b100, 3'd7, 1, 0, 0);
        set_vec( 8, 1, 0, 3'b000, 3'd0, 1, 1, 0);
        set_vec( 9, 1, 0, 3'b001, 3'd1, 1, 1, 0);
        set_vec(10, 1, 0, 3'b011, 3'd2, 1, 1, 0);
        set_vec(11, 1, 0, 3'b011, 3'd2, 1, 1, 0);
        set_vec(12, 0, 0, 3'b111, 3'd2, 1, 1, 0);
        set_vec(13, 0, 1, 3'b000, 3'd2, 0, 0, 0);
        set_vec(14, 1, 0, 3'b001, 3'd1, 1, 0, 0);
        set_vec(15, 1, 0, 3'b010, 3'd1, 0, 0, 1);
        set_vec(16, 1, 0, 3'b011, 3'd1, 0, 0, 1);
        set_vec(17, 1, 1, 3'b110, 3'd1, 0, 0, 0);
        set_vec(18, 1, 0, 3'b110, 3'd4, 1, 0, 0);

        Reset = 1'b0; Valid = 1'b0; Clear = 1'b0; Gray = '0;
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check("reset_state", dut_out(), 16'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("after_reset_idle", dut_out(), 16'd0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].valid, vecs[i].clear, vecs[i].gray);
            check($sformatf("vec%0d", i), dut_out(),
                  16'({vecs[i].bin, vecs[i].locked, vecs[i].wrap, vecs[i].err}));
        end

        // Advance to 5, reset between edges, relock at 6 with no step check.
        drive(1'b1, 1'b0, 3'b111);
        check("to_five", dut_out(), 16'({3'd5, 1'b1, 1'b0, 1'b0}));
        pulse_reset("midstream_reset");
        check("midstream_reset_zero", dut_out(), 16'd0);
        drive(1'b1, 1'b0, 3'b101);
        check("relock_six", dut_out(), 16'({3'd6, 1'b1, 1'b0, 1'b0}));
        // Backward step 6 -> 5 is a fault.
        drive(1'b1, 1'b0, 3'b111);
        check("backward_step", dut_out(), 16'({3'd6, 1'b0, 1'b0, 1'b1}));
        drive(1'b1, 1'b0, 3'b100);
        check("fault_holds", dut_out(), 16'({3'd6, 1'b0, 1'b0, 1'b1}));
        check_model("model_sync");

`ifdef GRAY_DECODER_ERRCNT_EN
        pulse_reset("cnt_reset");
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 3'b000);
            drive(1'b1, 1'b0, 3'b000);
            drive(1'b1, 1'b0, 3'b011);
        end
        drive(1'b0, 1'b1, 3'b000);
        check("errcnt_three", 16'(ErrCount), 16'd3);
        for (int k = 0; k < 257; k++) begin
            drive(1'b0, 1'b1, 3'b000);
            drive(1'b1, 1'b0, 3'b000);
            drive(1'b1, 1'b0, 3'b011);
        end
        check("errcnt_saturate", 16'(ErrCount), 16'd255);
        check_model("errcnt_model");
`endif

        // Random traffic biased toward legal steps so lock is held for long runs.
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 24) == 0);
            if (m_mode == 2 && $urandom_range(0, 3) == 0) c = 1'b1;
            r = int'($urandom_range(0, 3));
            if (r == 0) g = W'($urandom_range(0, (1 << W) - 1));
            else if (r == 1) g = W'(gray_of(m_bin));
            else g = W'(gray_of((m_bin + 1) % (1 << W)));
            drive(v, c, g);
            check_model($sformatf("rand%0d", i));
            if (i % 97 == 96) pulse_reset($sformatf("rand_reset%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
